// File: rtl/perceptron_pkg.sv
// Shared definitions for the perceptron UART link: command codes, default baud
// divider and the transmit state encoding.
package perceptron_pkg;

    localparam logic [2:0] CMD_LOAD_D1 = 3'd0;
    localparam logic [2:0] CMD_LOAD_D2 = 3'd1;
    localparam logic [2:0] CMD_OUT     = 3'd2;
    localparam logic [2:0] CMD_MUL     = 3'd5;
    localparam logic [2:0] CMD_MULADD  = 3'd6;

    localparam int DEFAULT_BAUD_DIV = 430;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        GAP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// Serialises one 8N1 byte. ready is also high in the final stop-bit clock so the
// next byte can follow with no idle clock in between.
//
// state | meaning
// IDLE  | line high, waiting for load
// START | start bit (low) for BAUD_DIV clocks
// DATA  | eight data bits LSB-first, BAUD_DIV clocks each
// STOP  | stop bit (high) for BAUD_DIV clocks
module uart_tx_byte
    import perceptron_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    tx_state_e     state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          baud_end;

    assign baud_end = (baud_cnt == CW'(BAUD_DIV - 1));
    assign ready    = (state == IDLE) || ((state == STOP) && baud_end);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else if (load && ready) begin
            state    <= START;
            tx       <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= data;
        end else begin
            case (state)
                IDLE: tx <= 1'b1;
                START: begin
                    if (baud_end) begin
                        state    <= DATA;
                        baud_cnt <= '0;
                        tx       <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shift   <= {1'b0, shift[7:1]};
                            tx      <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        state    <= IDLE;
                        baud_cnt <= '0;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/perceptron_result_tx.sv
// Sends one response frame (node address, then result bytes LSB-first) over 8N1
// UART, with optional idle-high gaps between bytes.
//
// state | meaning
// IDLE  | no frame in progress, start accepted
// START | frame latched, first byte handed to the serialiser next edge
// DATA  | a byte is on the line in the serialiser
// GAP   | idle-high spacing between bytes (down-counter)
module perceptron_result_tx
    import perceptron_pkg::*;
#(
    parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
    parameter int GAP_CYCLES = 0,
    parameter int RES_BYTES  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [7:0]             node_addr,
    input  logic [8*RES_BYTES-1:0] result,
    output logic                   uart_tx,
    output logic                   busy,
    output logic                   done
);

    localparam int FW = 8 * (RES_BYTES + 1);
    localparam int BW = $clog2(RES_BYTES + 1) + 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    tx_state_e     state;
    logic [FW-1:0] frame_sr;
    logic [BW-1:0] byte_cnt;
    logic [GW-1:0] gap_cnt;
    logic          byte_ready;
    logic          byte_end;
    logic          last_byte;
    logic          byte_load;

    assign byte_end  = (state == DATA) && byte_ready;
    assign last_byte = (byte_cnt == BW'(RES_BYTES));
    // Loading in the stop bit's final clock keeps bytes contiguous when there is no gap.
    assign byte_load = (state == START)
                     || ((state == GAP) && (gap_cnt == '0))
                     || (byte_end && !last_byte && (GAP_CYCLES == 0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            frame_sr <= '0;
            byte_cnt <= '0;
            gap_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (byte_load) begin
                frame_sr <= frame_sr >> 8;
                state    <= DATA;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        frame_sr <= {result, node_addr};
                        byte_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: ;
                DATA: begin
                    if (byte_end) begin
                        if (last_byte) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                            if (GAP_CYCLES > 0) begin
                                state   <= GAP;
                                gap_cnt <= GW'(GAP_CYCLES - 1);
                            end
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    uart_tx_byte #(
        .BAUD_DIV(BAUD_DIV)
    ) u_byte (
        .clk   (clk),
        .rst   (rst),
        .load  (byte_load),
        .data  (frame_sr[7:0]),
        .tx    (uart_tx),
        .ready (byte_ready)
    );

endmodule

// File: tb/tb_perceptron_result_tx.sv
// Bench for perceptron_result_tx: records the serial line every clock and decodes
// frames mid-bit against bytes and bit/frame timing derived from the frame rules.
module tb_perceptron_result_tx;

    localparam int MAXC = 100000;
    localparam int BA   = 430;
    localparam int BB   = 20;
    localparam int BC   = 20;
    localparam int GC   = 100;

    logic        clk = 1'b0;
    logic [2:0]  rst;
    logic [2:0]  start;
    logic [7:0]  addr;
    logic [31:0] res;
    wire  [2:0]  tx;
    wire  [2:0]  busy;
    wire  [2:0]  done;

    int cyc = 0;
    bit hist [3][MAXC];
    int n_done [3];
    int last_done [3];
    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (cyc < MAXC) hist[i][cyc] = tx[i];
            if (done[i] === 1'b1) begin
                n_done[i]++;
                last_done[i] = cyc;
            end
        end
    end

    perceptron_result_tx #(.BAUD_DIV(BA), .GAP_CYCLES(0), .RES_BYTES(4)) dut_a (
        .clk(clk), .rst(rst[0]), .start(start[0]), .node_addr(addr), .result(res),
        .uart_tx(tx[0]), .busy(busy[0]), .done(done[0]));

    perceptron_result_tx #(.BAUD_DIV(BB), .GAP_CYCLES(0), .RES_BYTES(4)) dut_b (
        .clk(clk), .rst(rst[1]), .start(start[1]), .node_addr(addr), .result(res),
        .uart_tx(tx[1]), .busy(busy[1]), .done(done[1]));

    perceptron_result_tx #(.BAUD_DIV(BC), .GAP_CYCLES(GC), .RES_BYTES(4)) dut_c (
        .clk(clk), .rst(rst[2]), .start(start[2]), .node_addr(addr), .result(res),
        .uart_tx(tx[2]), .busy(busy[2]), .done(done[2]));

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input int i, input logic [7:0] a, input logic [31:0] r, output int acc);
        @(negedge clk);
        addr     = a;
        res      = r;
        start[i] = 1'b1;
        acc      = cyc + 1;
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int limit, input string tag);
        int n;
        n = 0;
        while (done[i] !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("%s_done_seen", tag), done[i], 1);
    endtask

    // Decodes the recorded line like a host receiver would and checks byte timing.
    task automatic check_frame(input int i, input int acc, input int baud, input int gap,
                               input logic [7:0] a, input logic [31:0] r, input string tag);
        for (int j = 0; j < 5; j++) begin
            int s, lows, highs;
            logic [7:0] b, exp_b;
            s = acc + 1 + j * (10 * baud + gap);
            if (s + 10 * baud + gap >= MAXC) begin
                check($sformatf("%s_b%0d_range", tag, j), s, -1);
            end else begin
                exp_b = (j == 0) ? a : 8'((r >> (8 * (j - 1))) & 32'hFF);
                check($sformatf("%s_b%0d_idle_before", tag, j), hist[i][s-1], 1);
                lows = 0;
                for (int k = 0; k < baud; k++) lows += (hist[i][s+k] == 1'b0) ? 1 : 0;
                check($sformatf("%s_b%0d_start_len", tag, j), lows, baud);
                b = '0;
                for (int k = 0; k < 8; k++) b[k] = hist[i][s + (k + 1) * baud + baud / 2];
                check($sformatf("%s_b%0d_byte", tag, j), b, exp_b);
                check($sformatf("%s_b%0d_stop", tag, j), hist[i][s + 9 * baud + baud / 2], 1);
                if (gap > 0 && j < 4) begin
                    highs = 0;
                    for (int k = 0; k < gap; k++) highs += hist[i][s + 10 * baud + k] ? 1 : 0;
                    check($sformatf("%s_b%0d_gap", tag, j), highs, gap);
                end
            end
        end
    endtask

    task automatic finish_frame(input int i, input int acc, input logic [7:0] a, input logic [31:0] r,
                                input int baud, input int gap, input int n0, input string tag);
        wait_done(i, 50 * baud + 4 * gap + 20, tag);
        @(negedge clk);
        check($sformatf("%s_done_cnt", tag), n_done[i] - n0, 1);
        check($sformatf("%s_done_at", tag), last_done[i], acc + 1 + 50 * baud + 4 * gap);
        check($sformatf("%s_busy_after", tag), busy[i], 0);
        check_frame(i, acc, baud, gap, a, r, tag);
    endtask

    initial begin
        #(64'd98000 * 20);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2, n0, bad, s, target;
        logic [7:0]  a, a2;
        logic [31:0] r, r2;

        rst = 3'b111; start = '0; addr = '0; res = '0;
        for (int i = 0; i < 3; i++) begin n_done[i] = 0; last_done[i] = 0; end
        repeat (5) @(negedge clk);
        check("rst_tx", tx, 3'b111);
        check("rst_busy", busy, 3'b000);
        check("rst_done", done, 3'b000);
        rst = 3'b000;

        bad = 0;
        repeat (5000) begin
            @(negedge clk);
            if (tx !== 3'b111 || busy !== 3'b000 || done !== 3'b000) bad++;
        end
        check("idle_100us", bad, 0);

        n0 = n_done[0];
        send(0, 8'd100, 32'h0000_0001, acc);
        finish_frame(0, acc, 8'd100, 32'h0000_0001, BA, 0, n0, "s2");

        n0 = n_done[0];
        send(0, 8'd101, 32'hA5C3_0F80, acc);
        repeat (20 * BA + BA / 3) @(negedge clk);
        check("s4_busy_mid", busy[0], 1);
        addr = 8'd7; res = $urandom; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        finish_frame(0, acc, 8'd101, 32'hA5C3_0F80, BA, 0, n0, "s3");
        bad = 0;
        repeat (3 * BA) begin
            @(negedge clk);
            if (tx[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
        end
        check("s4_no_queue", bad, 0);
        check("s4_single_done", n_done[0] - n0, 1);

        a = 8'($urandom_range(0, 255)); r = $urandom;
        a2 = 8'($urandom_range(0, 255)); r2 = $urandom;
        n0 = n_done[1];
        send(1, a, r, acc);
        wait_done(1, 50 * BB + 20, "s5a");
        addr = a2; res = r2; start[1] = 1'b1; acc2 = cyc + 1;
        check("s5_busy_in_done", busy[1], 0);
        @(negedge clk);
        start[1] = 1'b0;
        check("s5_busy_b2b", busy[1], 1);
        check("s5a_done_at", last_done[1], acc + 1 + 50 * BB);
        check_frame(1, acc, BB, 0, a, r, "s5a");
        n0 = n_done[1];
        finish_frame(1, acc2, a2, r2, BB, 0, n0, "s5b");

        for (int f = 0; f < 3; f++) begin
            a = 8'($urandom_range(0, 255)); r = $urandom;
            n0 = n_done[2];
            send(2, a, r, acc);
            finish_frame(2, acc, a, r, BC, GC, n0, $sformatf("gap%0d", f));
        end

        a = 8'($urandom_range(0, 255)); r = $urandom & ~32'h0000_0800;
        n0 = n_done[1];
        send(1, a, r, acc);
        s = acc + 1 + 2 * 10 * BB;
        target = s + 4 * BB + BB / 2;
        while (cyc < target) @(negedge clk);
        check("s6_bit3_low", tx[1], 0);
        rst[1] = 1'b1;
        #1;
        check("s6_rst_tx", tx[1], 1);
        check("s6_rst_busy", busy[1], 0);
        repeat (3) @(negedge clk);
        rst[1] = 1'b0;
        bad = 0;
        repeat (20 * BB) begin
            @(negedge clk);
            if (tx[1] !== 1'b1 || busy[1] !== 1'b0) bad++;
        end
        check("s6_quiet", bad, 0);
        check("s6_no_done", n_done[1] - n0, 0);
        a = 8'($urandom_range(0, 255)); r = $urandom;
        n0 = n_done[1];
        send(1, a, r, acc);
        finish_frame(1, acc, a, r, BB, 0, n0, "s6_after");

        for (int f = 0; f < 3; f++) begin
            a = 8'($urandom_range(0, 255)); r = $urandom;
            n0 = n_done[1];
            send(1, a, r, acc);
            finish_frame(1, acc, a, r, BB, 0, n0, $sformatf("rnd%0d", f));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
